// File: rtl/wb_dma_rx_periph_if.sv
// Wishbone bus bundle shared by wb_dma_rx_periph and its master.
// ADR/SEL are full-width even though the peripheral decodes only ADR[3:2].
interface wb_if;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;

  modport master (output adr, dat_w, sel, we, cyc, stb, input dat_r, ack, err);
  modport slave  (input adr, dat_w, sel, we, cyc, stb, output dat_r, ack, err);
endinterface

// File: rtl/wb_dma_rx_periph.sv
// Receive-side DMA peripheral: producer FIFO drained by wb_dma over a Wishbone slave.
// Optional WB_DMA_RX_PERIPH_ND_EN: FIFO carries a last tag that pulses dma_nd_o on pop.
module wb_dma_rx_periph #(
  parameter int DEPTH   = 16,
  parameter int THR_RST = 4
) (
  input  logic        clk,
  input  logic        rst_i,
  wb_if.slave         s,
  input  logic        push_i,
  input  logic [31:0] push_data_i,
  input  logic        push_last_i,
  output logic        full_o,
  output logic        dma_req_o,
  input  logic        dma_ack_i,
  output logic        dma_nd_o,
  output logic        irq_o
);
  localparam int AW = $clog2(DEPTH);
`ifdef WB_DMA_RX_PERIPH_ND_EN
  localparam int FW = 33;
`else
  localparam int FW = 32;
`endif
  localparam logic [AW:0] PTR_ONE  = 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [8:0]  DEPTH9   = DEPTH[8:0];

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [FW-1:0] mem_q [DEPTH];
  logic [AW:0]   wp_q, rp_q, count;
  logic [8:0]    cnt9;
  logic          full, empty, acc, pop, push_ok, ovf_set, ovf_clr;
  logic [FW-1:0] head, push_word;

  logic          ack_q, ack_d, err_q, err_d;
  logic [31:0]   dat_r_q, dat_r_d;
  logic          en_q, en_d, ie_q, ie_d, ovf_q, ovf_d, nd_q, nd_d;
  logic [8:0]    thr_q, thr_d, thr_w;
  logic [1:0]    state_q, state_d;
  logic [31:0]   status, ctrl;

  assign count  = wp_q - rp_q;
  assign cnt9   = 9'(count);
  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign head   = mem_q[rp_q[AW-1:0]];
  assign status = {13'b0, ovf_q, full, empty, 7'b0, cnt9};
  assign ctrl   = {15'b0, thr_q, 6'b0, ie_q, en_q};
  assign thr_w  = s.dat_w[16:8];

  // A new access is only taken while no reply is on the bus.
  assign acc     = s.cyc & s.stb & ~ack_q & ~err_q;
  assign pop     = acc & ~s.we & (s.adr[3:2] == 2'd0) & ~empty;
  assign push_ok = push_i & (~full | pop);
  assign ovf_set = push_i & full & ~pop;

`ifdef WB_DMA_RX_PERIPH_ND_EN
  assign push_word = {push_last_i, push_data_i};
  assign nd_d      = pop & head[32];
`else
  assign push_word = push_data_i;
  assign nd_d      = 1'b0;
  logic unused_nd;
  assign unused_nd = push_last_i;
`endif

  logic unused_bits;
  assign unused_bits = ^{s.sel, s.adr[31:4], s.adr[1:0], s.dat_w[31:19], s.dat_w[17], s.dat_w[7:2]};

  always_comb begin
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_r_d = '0;
    en_d    = en_q;
    ie_d    = ie_q;
    thr_d   = thr_q;
    ovf_clr = 1'b0;
    if (acc) begin
      case (s.adr[3:2])
        2'd0: begin
          if (s.we || empty) err_d = 1'b1;
          else begin
            ack_d   = 1'b1;
            dat_r_d = head[31:0];
          end
        end
        2'd1: begin
          ack_d = 1'b1;
          if (s.we) ovf_clr = s.dat_w[18];
          else dat_r_d = status;
        end
        2'd2: begin
          ack_d = 1'b1;
          if (s.we) begin
            en_d  = s.dat_w[0];
            ie_d  = s.dat_w[1];
            thr_d = (thr_w > DEPTH9) ? DEPTH9 : thr_w;
          end else begin
            dat_r_d = ctrl;
          end
        end
        default: ack_d = 1'b1;
      endcase
    end
  end

  // Overflow set beats a same-cycle W1C so a drop is never lost.
  assign ovf_d = ovf_set | (ovf_q & ~ovf_clr);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en_q && (cnt9 >= thr_q)) state_d = ST_REQ;
      ST_REQ: begin
        if (!en_d) state_d = ST_IDLE;
        else if (dma_ack_i) state_d = ST_WAIT;
`ifdef WB_DMA_RX_PERIPH_ND_EN
        else if (nd_q) state_d = ST_IDLE;
`endif
      end
      ST_WAIT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q[AW-1:0]] <= push_word;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wp_q    <= '0;
      rp_q    <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_r_q <= '0;
      en_q    <= 1'b0;
      ie_q    <= 1'b0;
      thr_q   <= 9'(THR_RST);
      ovf_q   <= 1'b0;
      nd_q    <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      if (push_ok) wp_q <= wp_q + PTR_ONE;
      if (pop) rp_q <= rp_q + PTR_ONE;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_r_q <= dat_r_d;
      en_q    <= en_d;
      ie_q    <= ie_d;
      thr_q   <= thr_d;
      ovf_q   <= ovf_d;
      nd_q    <= nd_d;
      state_q <= state_d;
    end
  end

  assign s.ack     = ack_q;
  assign s.err     = err_q;
  assign s.dat_r   = dat_r_q;
  assign full_o    = full;
  assign dma_req_o = (state_q == ST_REQ);
  assign dma_nd_o  = nd_q;
  assign irq_o     = ie_q & ovf_q;
endmodule
